// File: rtl/serial_mem_slave_if.sv
// Bit-serial slave-slot bus between the arbiter and a memory-backed responder.
// Inbound bits travel on wr_bus/master_valid/slave_ready, outbound on rd_bus/slave_valid/master_ready.
interface serial_mem_slave_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic slave_ready;
  logic master_ready;
  logic rd_bus;
  logic slave_valid;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  slave_ready, rd_bus, slave_valid
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output slave_ready, rd_bus, slave_valid
  );
endinterface

// File: rtl/serial_mem_slave.sv
// Bit-serial memory slave: serial LSB-first address, then serial write data or read data.
// Optional wait states after the address phase when SLAVE_WAIT_EN is defined.
module serial_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input logic               clk,
  input logic               rstn,
  serial_mem_slave_if.slave bus
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
`ifdef SLAVE_WAIT_EN
    S_WAIT,
`endif
    S_WDATA,
    S_RREAD,
    S_RDATA
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   addr_sr, addr_n;
  logic [DATA_WIDTH-1:0]   data_sr, data_n;
  logic [DATA_WIDTH-1:0]   rd_sr, rd_n;
  logic                    mode_q, mode_n;
  logic                    mem_we;
  logic                    ready_int;

`ifdef SLAVE_WAIT_EN
  localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  logic [WAIT_W-1:0]       wait_cnt, wait_n;
`endif

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  assign ready_int       = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
  assign bus.slave_ready = ready_int;
  assign bus.slave_valid = (state == S_RDATA);
  assign bus.rd_bus      = (state == S_RDATA) & rd_sr[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      rd_sr    <= '0;
      mode_q   <= 1'b0;
`ifdef SLAVE_WAIT_EN
      wait_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_sr  <= addr_n;
      data_sr  <= data_n;
      rd_sr    <= rd_n;
      mode_q   <= mode_n;
`ifdef SLAVE_WAIT_EN
      wait_cnt <= wait_n;
`endif
    end
  end

  // Write uses data_n so the final serial bit lands in memory on its own beat.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_sr] <= data_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_sr;
    data_n  = data_sr;
    rd_n    = rd_sr;
    mode_n  = mode_q;
    mem_we  = 1'b0;
`ifdef SLAVE_WAIT_EN
    wait_n  = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (bus.master_valid) begin
          mode_n  = bus.mode;
          addr_n  = {bus.wr_bus, addr_sr[ADDR_WIDTH-1:1]};
          cnt_n   = CNT_W'(1);
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.master_valid) begin
          addr_n = {bus.wr_bus, addr_sr[ADDR_WIDTH-1:1]};
          if (cnt == ADDR_LAST) begin
            cnt_n = '0;
`ifdef SLAVE_WAIT_EN
            wait_n  = '0;
            state_n = S_WAIT;
`else
            state_n = mode_q ? S_WDATA : S_RREAD;
`endif
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
`ifdef SLAVE_WAIT_EN
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_n = mode_q ? S_WDATA : S_RREAD;
        else                       wait_n  = wait_cnt + WAIT_W'(1);
      end
`endif
      S_WDATA: begin
        if (bus.master_valid) begin
          data_n = {bus.wr_bus, data_sr[DATA_WIDTH-1:1]};
          if (cnt == DATA_LAST) begin
            mem_we  = 1'b1;
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      S_RREAD: begin
        rd_n    = mem[addr_sr];
        cnt_n   = '0;
        state_n = S_RDATA;
      end
      S_RDATA: begin
        if (bus.master_ready) begin
          rd_n = {1'b0, rd_sr[DATA_WIDTH-1:1]};
          if (cnt == DATA_LAST) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
